// File: rtl/burst_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : burst_line_adaptor
// Purpose  : Memory-side responder for a cache line port. Turns one line read
//            or line write into a BEATS-beat burst toward physical memory,
//            assembles or serialises the line, and returns a one-cycle resp_o.
// Revision : 1.0 - initial release
// ============================================================================
module burst_line_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  // cache side
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  // memory side
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int c_BEATS     = LINE_W / BEAT_W;
  localparam int c_BEAT_BITS = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_OFS_BITS  = $clog2(LINE_W / 8);

  localparam logic [c_BEAT_BITS-1:0] c_LAST_BEAT = c_BEAT_BITS'(c_BEATS - 1);
  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam logic [ADDR_W-1:0] c_ADDR_MASK =
    {{(ADDR_W - c_OFS_BITS){1'b1}}, {c_OFS_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_BEAT_BITS-1:0] r_beat;
  logic [ADDR_W-1:0]      r_addr;
  logic [LINE_W-1:0]      r_wr_line;
  logic [LINE_W-1:0]      r_rd_line;
  logic                   r_read;
  logic                   r_write;
  logic                   r_resp;
  logic [ADDR_W-1:0]      w_addr_aligned;

  assign w_addr_aligned = address_i & c_ADDR_MASK;

  // Burst FSM: request capture, beat counting, line assembly and the
  // registered strobes/response, all in one clocked process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_addr    <= '0;
      r_wr_line <= '0;
      r_rd_line <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_resp    <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Read has priority; a held write is simply taken after the read.
          if (read_i) begin
            r_addr  <= w_addr_aligned;
            r_beat  <= '0;
            r_read  <= 1'b1;
            r_state <= ST_RD_BURST;
          end else if (write_i) begin
            r_addr    <= w_addr_aligned;
            r_wr_line <= line_i;
            r_beat    <= '0;
            r_write   <= 1'b1;
            r_state   <= ST_WR_BURST;
          end
        end
        ST_RD_BURST: begin
          if (resp_i) begin
            r_rd_line[BEAT_W*r_beat +: BEAT_W] <= burst_i;
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_LAST_BEAT) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_WR_BURST: begin
          if (resp_i) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_LAST_BEAT) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Requests are ignored here so the cache can drop them next cycle.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers; the write beat is a slice of the
  // captured line selected by the registered beat counter.
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;
  assign address_o = r_addr;
  assign line_o    = r_rd_line;
  assign burst_o   = r_wr_line[BEAT_W*r_beat +: BEAT_W];

endmodule
`default_nettype wire

// File: tb/tb_burst_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_line_adaptor
// Purpose  : Randomised self-checking bench for burst_line_adaptor with a
//            transaction-level reference model of the line/burst protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_line_adaptor;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [LINE_W-1:0] line_i = '0;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i = '0;
  logic              read_i = 1'b0;
  logic              write_i = 1'b0;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i = '0;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i = 1'b0;

  always #5 clk = ~clk;

  burst_line_adaptor #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the line the cache should currently see, the
  // data memory returns for the next read, and the line the cache writes.
  logic [LINE_W-1:0] exp_line = '0;
  logic [BEAT_W-1:0] rd_beats [BEATS];
  logic [LINE_W-1:0] wr_line = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic rand_beats();
    for (int i = 0; i < BEATS; i++) rd_beats[i] = {$urandom, $urandom};
  endtask

  task automatic check_quiet(input string where);
    check({where, "_read_o"},  256'(read_o),  256'(0));
    check({where, "_write_o"}, 256'(write_o), 256'(0));
    check({where, "_resp_o"},  256'(resp_o),  256'(0));
    check({where, "_line_o"},  256'(line_o),  256'(exp_line));
  endtask

  // One IDLE cycle, optionally with a stray memory acknowledge.
  task automatic idle_cycle(input bit stray);
    check_quiet("idle");
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = rand_line();
    burst_i   = {$urandom, $urandom};
    resp_i    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
  endtask

  task automatic check_zero_outputs(input string where);
    check({where, "_read_o"},    256'(read_o),    256'(0));
    check({where, "_write_o"},   256'(write_o),   256'(0));
    check({where, "_resp_o"},    256'(resp_o),    256'(0));
    check({where, "_burst_o"},   256'(burst_o),   256'(0));
    check({where, "_address_o"}, 256'(address_o), 256'(0));
    check({where, "_line_o"},    256'(line_o),    256'(0));
  endtask

  // Issue one line request in the current (IDLE) cycle and act as memory
  // with wmin..wmax wait cycles before each ack. abort_at >= 0 pulls reset
  // just before the ack of that beat.
  task automatic run_txn(input bit do_rd, input bit do_wr, input logic [ADDR_W-1:0] addr,
                         input int wmin, input int wmax, input int abort_at);
    bit                is_rd;
    bit                hold;
    int                w;
    logic [ADDR_W-1:0] exp_addr;
    is_rd    = do_rd;
    exp_addr = {addr[ADDR_W-1:5], 5'b0};
    hold     = 1'($urandom_range(0, 1));

    check_quiet("req");
    read_i    = do_rd;
    write_i   = do_wr;
    address_i = addr;
    line_i    = wr_line;
    resp_i    = 1'($urandom_range(0, 1));
    burst_i   = {$urandom, $urandom};
    tick();

    for (int b = 0; b < BEATS; b++) begin
      w = int'($urandom_range(wmax, wmin));
      for (int k = 0; k <= w; k++) begin
        check("burst_read_o",  256'(read_o),    256'(is_rd));
        check("burst_write_o", 256'(write_o),   256'(!is_rd));
        check("burst_resp_o",  256'(resp_o),    256'(0));
        check("burst_addr_o",  256'(address_o), 256'(exp_addr));
        check("burst_line_o",  256'(line_o),    256'(exp_line));
        if (!is_rd)
          check("burst_data_o", 256'(burst_o), 256'(wr_line[b*BEAT_W +: BEAT_W]));
        if (b == abort_at && k == w) begin
          rst      = 1'b0;
          read_i   = 1'b0;
          write_i  = 1'b0;
          resp_i   = 1'b0;
          exp_line = '0;
          #1;
          check_zero_outputs("rst_async");
          tick();
          tick();
          check_zero_outputs("rst_held");
          rst = 1'b1;
          return;
        end
        read_i    = hold ? do_rd : 1'b0;
        write_i   = hold ? do_wr : 1'b0;
        address_i = $urandom;
        line_i    = rand_line();
        resp_i    = (k == w);
        burst_i   = (k == w) ? rd_beats[b] : {$urandom, $urandom};
        tick();
        if (k == w && is_rd) exp_line[b*BEAT_W +: BEAT_W] = rd_beats[b];
      end
    end

    // DONE cycle: single response, requests and acks are don't-care.
    check("done_resp_o",  256'(resp_o),  256'(1));
    check("done_read_o",  256'(read_o),  256'(0));
    check("done_write_o", 256'(write_o), 256'(0));
    check("done_line_o",  256'(line_o),  256'(exp_line));
    read_i    = 1'($urandom_range(0, 1));
    write_i   = 1'($urandom_range(0, 1));
    address_i = $urandom;
    resp_i    = 1'($urandom_range(0, 1));
    burst_i   = {$urandom, $urandom};
    tick();
  endtask

  initial begin
    // Reset state
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed read with back-to-back beats
    rd_beats[0] = {16{4'h1}};
    rd_beats[1] = {16{4'h2}};
    rd_beats[2] = {16{4'h3}};
    rd_beats[3] = {16{4'h4}};
    run_txn(1'b1, 1'b0, 32'h0000_1234, 0, 0, -1);
    check("tp_read_line", 256'(line_o), {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    idle_cycle(1'b0);

    // Directed write with two wait cycles before each ack
    wr_line = rand_line();
    run_txn(1'b0, 1'b1, 32'h8000_0040, 2, 2, -1);

    // Write-back immediately followed by a line fill
    wr_line = rand_line();
    run_txn(1'b0, 1'b1, $urandom, 0, 3, -1);
    rand_beats();
    run_txn(1'b1, 1'b0, $urandom, 0, 3, -1);

    // Simultaneous read and write: read goes first, then stray acks in IDLE
    rand_beats();
    wr_line = rand_line();
    run_txn(1'b1, 1'b1, $urandom, 0, 1, -1);
    for (int i = 0; i < 6; i++) idle_cycle(1'b1);

    // Reset after the second read beat, then a clean read
    rand_beats();
    run_txn(1'b1, 1'b0, $urandom, 0, 1, 2);
    rand_beats();
    run_txn(1'b1, 1'b0, 32'h0000_1234, 0, 0, -1);

    // Randomised traffic
    for (int t = 0; t < 60; t++) begin
      int gap;
      bit r;
      bit wr;
      r  = 1'($urandom_range(0, 1));
      wr = r ? 1'($urandom_range(0, 1)) : 1'b1;
      rand_beats();
      wr_line = rand_line();
      run_txn(r, wr, $urandom, 0, 3, -1);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) idle_cycle(1'b1);
    end

    idle_cycle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
